tlc_param_ctrl: RTL

- Parametrised, sensor-actuated two-approach traffic light controller.
- Main approach is L1. NUM_SIDE side lights are always driven identically.
- Successor to the fixed-timing controller:
  - all phase durations are parameters;
  - a one-second prescaler is built in;
  - side green is demand-extended;
  - a Fault input forces a failsafe.
- State is exported so the bound assertion module can check state/light consistency.

---
 rtl/tlc_param_ctrl_if.sv | 30 +++
 rtl/tlc_param_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_param_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tlc_param_ctrl_if
// Description : Sensor/fault inputs and light/state/tick outputs of the
//               parametrised traffic light controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlc_param_ctrl_if #(
    parameter int NUM_SIDE = 2
);
    logic                    s_main;
    logic [NUM_SIDE-1:0]     s_side;
    logic                    fault;
    logic [1:0]              l1;
    logic [2*NUM_SIDE-1:0]   l_side;
    logic [3:0]              state;
    logic                    tick;

    // master: environment (sensors), slave: controller
    modport master (
        output s_main, s_side, fault,
        input  l1, l_side, state, tick
    );

    modport slave (
        input  s_main, s_side, fault,
        output l1, l_side, state, tick
    );
endinterface
`default_nettype wire

// File: rtl/tlc_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlc_param_ctrl
// Description : Parametrised, sensor-actuated two-approach traffic light
//               controller with one-second prescaler, demand-extended side
//               green and fault failsafe. Optional flashing failsafe is
//               enabled by defining TLC_FLASH_FAILSAFE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_param_ctrl #(
    parameter int CLK_PER_SEC    = 1,
    parameter int MAIN_MIN_GREEN = 45,
    parameter int SIDE_GREEN     = 15,
    parameter int SIDE_MAX       = 30,
    parameter int YELLOW_T       = 5,
    parameter int ALLRED_T       = 1,
    parameter int NUM_SIDE       = 2,
    parameter int TW             = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tlc_param_ctrl_if.slave    bus
);

    typedef enum logic [3:0] {
        ST_ALLRED_TO_MAIN = 4'd0,
        ST_MAIN_GREEN     = 4'd1,
        ST_MAIN_WAIT      = 4'd2,
        ST_MAIN_YELLOW    = 4'd3,
        ST_ALLRED_TO_SIDE = 4'd4,
        ST_SIDE_GREEN     = 4'd5,
        ST_SIDE_EXT       = 4'd6,
        ST_SIDE_YELLOW    = 4'd7,
        ST_FAILSAFE       = 4'd8
    } state_t;

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    localparam logic [PW-1:0] c_PRESC_MAX = PW'(CLK_PER_SEC - 1);
    localparam logic [TW-1:0] c_LD_ALLRED = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] c_LD_MAIN   = TW'(MAIN_MIN_GREEN - 1);
    localparam logic [TW-1:0] c_LD_YELLOW = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] c_LD_SIDE   = TW'(SIDE_GREEN - 1);
    localparam logic [TW-1:0] c_LD_EXT    = TW'(SIDE_MAX - SIDE_GREEN - 1);
    localparam bit            c_EXT_EN    = (SIDE_MAX > SIDE_GREEN);

    localparam logic [1:0] c_GRN  = 2'b01;
    localparam logic [1:0] c_YEL  = 2'b10;
    localparam logic [1:0] c_RED  = 2'b11;
    localparam logic [1:0] c_DARK = 2'b00;

    logic [PW-1:0] r_presc;
    logic          w_tick;
    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_sec;
    logic [TW-1:0] w_sec_nxt;
    logic          w_demand;
    logic          w_expire;
    logic [1:0]    r_l1;
    logic [1:0]    r_side;
    logic [1:0]    w_l1_nxt;
    logic [1:0]    w_side_nxt;

    // ------------------------------------------------------------------
    // One-second prescaler; free-running, including through FAILSAFE
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_PRESC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_demand = |bus.s_side;
    assign w_expire = w_tick && (r_sec == '0);

    // ------------------------------------------------------------------
    // State and seconds-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ALLRED_TO_MAIN;
            r_sec   <= c_LD_ALLRED;
        end else begin
            r_state <= w_next;
            r_sec   <= w_sec_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter reload
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_sec_nxt = r_sec;

        if (w_tick && (r_sec != '0)) begin
            w_sec_nxt = r_sec - 1'b1;
        end

        case (r_state)
            ST_ALLRED_TO_MAIN: begin
                if (w_expire) begin
                    w_next    = ST_MAIN_GREEN;
                    w_sec_nxt = c_LD_MAIN;
                end
            end
            ST_MAIN_GREEN: begin
                if (w_expire) begin
                    w_next = ST_MAIN_WAIT;
                end
            end
            ST_MAIN_WAIT: begin
                if (w_tick && w_demand) begin
                    w_next    = ST_MAIN_YELLOW;
                    w_sec_nxt = c_LD_YELLOW;
                end
            end
            ST_MAIN_YELLOW: begin
                if (w_expire) begin
                    w_next    = ST_ALLRED_TO_SIDE;
                    w_sec_nxt = c_LD_ALLRED;
                end
            end
            ST_ALLRED_TO_SIDE: begin
                if (w_expire) begin
                    w_next    = ST_SIDE_GREEN;
                    w_sec_nxt = c_LD_SIDE;
                end
            end
            ST_SIDE_GREEN: begin
                if (w_expire) begin
                    if (c_EXT_EN && w_demand && !bus.s_main) begin
                        w_next    = ST_SIDE_EXT;
                        w_sec_nxt = c_LD_EXT;
                    end else begin
                        w_next    = ST_SIDE_YELLOW;
                        w_sec_nxt = c_LD_YELLOW;
                    end
                end
            end
            ST_SIDE_EXT: begin
                // Extension ends early once demand drops or main traffic waits
                if (w_tick && (!w_demand || bus.s_main || (r_sec == '0))) begin
                    w_next    = ST_SIDE_YELLOW;
                    w_sec_nxt = c_LD_YELLOW;
                end
            end
            ST_SIDE_YELLOW: begin
                if (w_expire) begin
                    w_next    = ST_ALLRED_TO_MAIN;
                    w_sec_nxt = c_LD_ALLRED;
                end
            end
            ST_FAILSAFE: begin
                w_next    = ST_ALLRED_TO_MAIN;
                w_sec_nxt = c_LD_ALLRED;
            end
            default: begin
                w_next = ST_FAILSAFE;
            end
        endcase

        // Fault overrides every transition, including leaving FAILSAFE
        if (bus.fault) begin
            w_next = ST_FAILSAFE;
        end
    end

`ifdef TLC_FLASH_FAILSAFE_EN
    logic r_flash;
    logic w_flash_nxt;

    // Lit phase on FAILSAFE entry, then toggles every second
    assign w_flash_nxt = (r_state != ST_FAILSAFE) ? 1'b1 :
                         (w_tick ? ~r_flash : r_flash);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash <= 1'b1;
        end else begin
            r_flash <= w_flash_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Light decode from the next state so lights change with State
    // ------------------------------------------------------------------
    always_comb begin
        w_l1_nxt   = c_RED;
        w_side_nxt = c_RED;
        case (w_next)
            ST_MAIN_GREEN,
            ST_MAIN_WAIT:   w_l1_nxt   = c_GRN;
            ST_MAIN_YELLOW: w_l1_nxt   = c_YEL;
            ST_SIDE_GREEN,
            ST_SIDE_EXT:    w_side_nxt = c_GRN;
            ST_SIDE_YELLOW: w_side_nxt = c_YEL;
            ST_FAILSAFE: begin
`ifdef TLC_FLASH_FAILSAFE_EN
                if (w_flash_nxt) begin
                    w_l1_nxt   = c_YEL;
                    w_side_nxt = c_RED;
                end else begin
                    w_l1_nxt   = c_DARK;
                    w_side_nxt = c_DARK;
                end
`else
                w_l1_nxt   = c_RED;
                w_side_nxt = c_RED;
`endif
            end
            default: begin
                w_l1_nxt   = c_RED;
                w_side_nxt = c_RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l1   <= c_RED;
            r_side <= c_RED;
        end else begin
            r_l1   <= w_l1_nxt;
            r_side <= w_side_nxt;
        end
    end

    assign bus.l1     = r_l1;
    assign bus.l_side = {NUM_SIDE{r_side}};
    assign bus.state  = r_state;
    assign bus.tick   = w_tick;

endmodule
`default_nettype wire
